line_read_buffer: RTL and testbench
===================================

// Module: line_read_buffer
// PURPOSE
//  CPU-side read port for 128-bit lines; the read-direction counterpart of the store-merge path.
//  Sits between the datapath memory interface and the L1 line interface.
//  Holds one buffered line (tag plus valid) and answers word or byte reads from it.
//  On a miss it fetches the line, then extracts the addressed word or byte.
//  Store-path line writes are snooped so the buffer never returns stale data.
// PARAMETERS
//  ADDR_W       16  byte-address width
//  OFFSET_W      4  line offset bits; line width = 8 << OFFSET_W = 128
// PORTS
//  clk               in   1    single clock, all state on rising edge
//  reset_n           in   1    asynchronous, active-low reset
//  mem_read          in   1    CPU read request; held high until mem_resp
//  mem_address       in   16   CPU byte address
//  mem_byte_enable   in   2    2'b11 = word access, any other value = byte access
//  mem_rdata         out  16   read data, valid while mem_resp = 1
//  mem_resp          out  1    one-cycle completion pulse
//  line_read         out  1    line fetch request; held until line_resp
//  line_address      out  16   {tag, 4'b0000}, stable while line_read = 1
//  line_rdata        in   128  fetched line, sampled when line_resp = 1
//  line_resp         in   1    fetch complete
//  line_write        in   1    store path is writing a merged line this cycle
//  line_write_addr   in   16   address of the written line (offset bits ignored)
//  line_write_data   in   128  merged line being written
// BEHAVIOUR
//  Reset (asynchronous): state = IDLE, valid = 0, tag = 0, line = 0, mem_rdata = 0,
//   mem_resp = 0, line_read = 0, line_address = 0, stale = 0. Reset mid-fetch drops line_read at once.
//  FSM states: IDLE, FETCH, RESP.
//   IDLE, mem_read = 1 and hit (valid && tag == addr[15:4]):
//    register extracted data into mem_rdata, go to RESP.
//   IDLE, mem_read = 1 and miss: latch the fetch tag, clear stale, go to FETCH.
//   FETCH: line_read = 1.
//    line_resp && !stale: load line, set valid, set tag, register extract, go to RESP.
//    line_resp && stale: discard the data, clear stale, spend one cycle in IDLE with line_read = 0,
//     then refetch automatically; mem_read is still high and the access now misses.
//   RESP: mem_resp = 1 for exactly one cycle, then return to IDLE.
//    The cycle after RESP can accept a new request.
//  Latency: hit = mem_resp 1 cycle after the request is sampled.
//   Miss = mem_resp 1 cycle after line_resp.
//  Extraction:
//   Word: line[16*off[3:1] +: 16]; off[0] is ignored.
//   Byte: {8'h00, line[8*off +: 8]}; zero-extended, sign handling is the datapath's job.
//  Snoop on line_write with line_write_addr[15:4] == tag:
//   valid buffer, any state except the fill cycle: replace line with line_write_data.
//   FETCH, matching the fetch tag: set stale.
//   Same cycle as line_resp: stale wins and a refetch occurs.
//   RESP: mem_rdata is already registered and stays unaffected.
//  Non-matching line_write is ignored. A miss evicts the single buffered line; there is no write-back (read-only buffer).
//  mem_read dropping before mem_resp is illegal; this is an assertion, not handled.
// STRUCTURE
//  lc3b_types package gains:
//   typedef logic [127:0] lc3b_line
//   typedef logic [11:0] lc3b_line_tag
//   typedef enum {IDLE, FETCH, RESP} lrb_state_t
//   localparam LINE_OFFSET_W = 4
//  Sub-module line_extract (combinational): line, offset, byte_enable -> 16-bit word.
//   It is the exact inverse of the store-merge placement.
//  Top level holds the FSM, the tag/valid/line registers, the stale flag and the snoop compare.
// TESTING
//  Fill line: byte i = i, so line = 128'h0F0E..0100.
//  1. Reset, word read at 0x1006 -> line_read = 1, line_address = 0x1000.
//     Give line_resp with the fill line -> next cycle mem_resp = 1, mem_rdata = 0x0706.
//  2. Then byte read at 0x100F -> no line_read, mem_resp 1 cycle later, mem_rdata = 0x000F.
//     Word read at 0x1007 -> 0x0706.
//  3. Read at 0x2000 (miss, evicts) then read at 0x1002 -> second line_read with line_address = 0x1000.
//  4. Buffer holds 0x1000. line_write to 0x1004 with data all 0xAA in IDLE.
//     Word read at 0x1000 -> 0xAAAA with no line_read.
//  5. Miss on 0x3000; line_write to 0x3008 during FETCH -> first line_resp discarded.
//     line_read low one cycle, then reasserted. mem_rdata comes from the second fill.
//  6. reset_n low during FETCH -> line_read = 0 and mem_resp = 0 immediately.
//     After release, a read of the same line misses.

Source files
------------

// File: rtl/line_read_buffer_pkg.sv
// ---------------------------------------------------------------------------
// lc3b_types
//   Shared types for the LC-3b cache-side line paths.
//   Holds the 128-bit line and 12-bit line-tag types, the line offset width
//   and the state encoding of the line read buffer FSM.
// ---------------------------------------------------------------------------
package lc3b_types;

  // Byte offset bits inside one cache line (16 bytes per line).
  localparam int LINE_OFFSET_W = 4;

  typedef logic [127:0] lc3b_line;
  typedef logic [11:0]  lc3b_line_tag;

  // Read buffer states:
  //   IDLE  - waiting for a request (or re-issuing a fetch after a stale fill)
  //   FETCH - line fetch outstanding on the L1 line interface
  //   RESP  - mem_resp pulse cycle
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RESP  = 2'd2
  } lrb_state_t;

endpackage

// File: rtl/line_read_buffer_extract.sv
// ---------------------------------------------------------------------------
// line_extract
//   Combinational word/byte selector for one cache line. It is the exact
//   inverse of the store-merge placement: a word access returns the aligned
//   16-bit word holding the addressed byte (offset bit 0 ignored), a byte
//   access returns the addressed byte zero-extended to 16 bits.
//
// Ports
//   i_line         in  8<<OFFSET_W  line to extract from
//   i_offset       in  OFFSET_W     byte offset inside the line
//   i_byte_enable  in  2            2'b11 = word access, else byte access
//   o_data         out 16           extracted, zero-extended data
// ---------------------------------------------------------------------------
module line_extract #(
  parameter int OFFSET_W = 4
) (
  input  logic [(8 << OFFSET_W)-1:0] i_line,
  input  logic [OFFSET_W-1:0]        i_offset,
  input  logic [1:0]                 i_byte_enable,
  output logic [15:0]                o_data
);

  localparam int N_BYTES = 1 << OFFSET_W;
  localparam int N_WORDS = N_BYTES / 2;

  logic [7:0]  w_bytes [N_BYTES];
  logic [15:0] w_words [N_WORDS];

  genvar gi;
  generate
    for (gi = 0; gi < N_BYTES; gi++) begin : g_bytes
      assign w_bytes[gi] = i_line[8*gi +: 8];
    end
    for (gi = 0; gi < N_WORDS; gi++) begin : g_words
      assign w_words[gi] = i_line[16*gi +: 16];
    end
  endgenerate

  always_comb begin
    o_data = 16'h0000;
    if (i_byte_enable == 2'b11) begin
      o_data = w_words[i_offset[OFFSET_W-1:1]];
    end else begin
      // Zero extension only; sign handling belongs to the datapath.
      o_data = {8'h00, w_bytes[i_offset]};
    end
  end

endmodule

// File: rtl/line_read_buffer.sv
// ---------------------------------------------------------------------------
// line_read_buffer
//   CPU-side read port for 128-bit lines. Keeps a single buffered line
//   (tag + valid) and serves word/byte reads from it. A miss evicts the
//   buffered line and fetches the addressed one over the L1 line interface.
//   Store-path line writes are snooped: a write to the buffered line
//   replaces it, a write to the line currently being fetched marks the
//   fetch stale so the returned data is discarded and the line refetched.
//
// Ports
//   clk              in   1    clock, all state on the rising edge
//   reset_n          in   1    asynchronous active-low reset
//   mem_read         in   1    CPU read request, held until mem_resp
//   mem_address      in   16   CPU byte address
//   mem_byte_enable  in   2    2'b11 word access, otherwise byte access
//   mem_rdata        out  16   read data, valid while mem_resp = 1
//   mem_resp         out  1    one-cycle completion pulse
//   line_read        out  1    line fetch request, held until line_resp
//   line_address     out  16   {tag, 4'b0000} of the line being fetched
//   line_rdata       in   128  fetched line, sampled on line_resp
//   line_resp        in   1    fetch complete
//   line_write       in   1    store path writes a merged line this cycle
//   line_write_addr  in   16   address of the written line
//   line_write_data  in   128  merged line being written
// ---------------------------------------------------------------------------
module line_read_buffer
  import lc3b_types::*;
#(
  parameter int ADDR_W   = 16,
  parameter int OFFSET_W = LINE_OFFSET_W
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        mem_read,
  input  logic [ADDR_W-1:0]           mem_address,
  input  logic [1:0]                  mem_byte_enable,
  output logic [15:0]                 mem_rdata,
  output logic                        mem_resp,
  output logic                        line_read,
  output logic [ADDR_W-1:0]           line_address,
  input  logic [(8 << OFFSET_W)-1:0]  line_rdata,
  input  logic                        line_resp,
  input  logic                        line_write,
  input  logic [ADDR_W-1:0]           line_write_addr,
  input  logic [(8 << OFFSET_W)-1:0]  line_write_data
);

  localparam int LINE_W = 8 << OFFSET_W;
  localparam int TAG_W  = ADDR_W - OFFSET_W;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  lrb_state_t         r_state;
  logic               r_valid;
  logic [TAG_W-1:0]   r_tag;
  logic [LINE_W-1:0]  r_line;
  logic [TAG_W-1:0]   r_fetch_tag;
  logic               r_stale;
  logic [15:0]        r_rdata;
  logic               r_resp;
  logic               r_line_read;

  // -------------------------------------------------------------------------
  // Address split, hit and snoop compares
  // -------------------------------------------------------------------------
  logic [TAG_W-1:0]    w_req_tag;
  logic [OFFSET_W-1:0] w_req_off;
  logic [TAG_W-1:0]    w_wr_tag;
  logic                w_hit;
  logic                w_snoop_buf;
  logic                w_snoop_fetch;
  logic [LINE_W-1:0]   w_cur_line;
  logic [LINE_W-1:0]   w_src_line;
  logic [15:0]         w_extract;
  logic                w_unused_wr_offset;

  assign w_req_tag = mem_address[ADDR_W-1:OFFSET_W];
  assign w_req_off = mem_address[OFFSET_W-1:0];
  assign w_wr_tag  = line_write_addr[ADDR_W-1:OFFSET_W];

  // Offset bits of the snooped write address do not matter: whole lines move.
  assign w_unused_wr_offset = &{1'b0, line_write_addr[OFFSET_W-1:0]};

  assign w_hit = r_valid && (r_tag == w_req_tag);

  // The buffer is invalidated when a fetch starts, so a valid buffer and an
  // outstanding fill never coexist; no extra fill-cycle qualifier is needed.
  assign w_snoop_buf   = line_write && r_valid && (w_wr_tag == r_tag);
  assign w_snoop_fetch = line_write && (r_state == FETCH) && (w_wr_tag == r_fetch_tag);

  // A hit in the same cycle as a matching store-path write returns the new
  // line content, so the read can never observe the superseded data.
  assign w_cur_line = w_snoop_buf ? line_write_data : r_line;

  // In FETCH the extract source is the incoming line (fill cycle).
  assign w_src_line = (r_state == FETCH) ? line_rdata : w_cur_line;

  line_extract #(
    .OFFSET_W (OFFSET_W)
  ) u_extract (
    .i_line        (w_src_line),
    .i_offset      (w_req_off),
    .i_byte_enable (mem_byte_enable),
    .o_data        (w_extract)
  );

  // -------------------------------------------------------------------------
  // FSM and buffer registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_valid     <= 1'b0;
      r_tag       <= '0;
      r_line      <= '0;
      r_fetch_tag <= '0;
      r_stale     <= 1'b0;
      r_rdata     <= 16'h0000;
      r_resp      <= 1'b0;
      r_line_read <= 1'b0;
    end else begin
      if (w_snoop_buf) begin
        r_line <= line_write_data;
      end

      case (r_state)
        IDLE: begin
          if (mem_read) begin
            if (w_hit) begin
              r_rdata <= w_extract;
              r_resp  <= 1'b1;
              r_state <= RESP;
            end else begin
              // Single-line buffer: a miss evicts the current line.
              r_valid     <= 1'b0;
              r_fetch_tag <= w_req_tag;
              r_stale     <= 1'b0;
              r_line_read <= 1'b1;
              r_state     <= FETCH;
            end
          end
        end

        FETCH: begin
          if (line_resp) begin
            r_line_read <= 1'b0;
            if (r_stale || w_snoop_fetch) begin
              // Fill is older than a store that hit this line: drop it and
              // let IDLE re-issue the fetch since mem_read is still held.
              r_stale <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_line  <= line_rdata;
              r_valid <= 1'b1;
              r_tag   <= r_fetch_tag;
              r_rdata <= w_extract;
              r_resp  <= 1'b1;
              r_state <= RESP;
            end
          end else if (w_snoop_fetch) begin
            r_stale <= 1'b1;
          end
        end

        RESP: begin
          r_resp  <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_resp      <= 1'b0;
          r_line_read <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign mem_rdata    = r_rdata;
  assign mem_resp     = r_resp;
  assign line_read    = r_line_read;
  assign line_address = {r_fetch_tag, {OFFSET_W{1'b0}}};

  // A CPU read must stay asserted while its line fetch is outstanding.
  a_read_held_during_fetch : assert property (
    @(posedge clk) disable iff (!reset_n)
    (r_state == FETCH) |-> mem_read
  );

endmodule

// File: tb/tb_line_read_buffer.sv
module tb_line_read_buffer;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         mem_read;
  logic [15:0]  mem_address;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  logic         line_read;
  logic [15:0]  line_address;
  logic [127:0] line_rdata;
  logic         line_resp;
  logic         line_write;
  logic [15:0]  line_write_addr;
  logic [127:0] line_write_data;

  always #5 clk = ~clk;

  line_read_buffer dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .mem_read        (mem_read),
    .mem_address     (mem_address),
    .mem_byte_enable (mem_byte_enable),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .line_read       (line_read),
    .line_address    (line_address),
    .line_rdata      (line_rdata),
    .line_resp       (line_resp),
    .line_write      (line_write),
    .line_write_addr (line_write_addr),
    .line_write_data (line_write_data)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [15:0] addr;
    logic [1:0]  be;
    logic [15:0] exp;
    bit          miss;
    logic [7:0]  base;
  } vec_t;

  vec_t vecs[10];

  // Line whose byte i holds base + i.
  function automatic logic [127:0] fill_line(input logic [7:0] base);
    logic [127:0] l;
    l = '0;
    for (int i = 0; i < 16; i++) l[8*i +: 8] = base + 8'(i);
    return l;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_line_read(input string nm, input logic [15:0] exp_addr);
    for (int i = 0; i < 8 && !line_read; i++) @(negedge clk);
    if (!line_read) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s line_read timeout: got 0, expected 1", nm);
    end else begin
      chk({nm, " line_address"}, line_address, exp_addr);
    end
  endtask

  task automatic wait_resp(input string nm);
    logic [15:0] e;
    chk({nm, " resp_latency"}, mem_resp, 1'b1);
    for (int i = 0; i < 8 && !mem_resp; i++) @(negedge clk);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    if (mem_resp) begin
      chk({nm, " rdata"}, mem_rdata, e);
      $display("txn %s: addr=%h rdata=%h expected=%h", nm, mem_address, mem_rdata, e);
    end else begin
      n_checks++;
      n_fail++;
      $display("FAIL %s mem_resp timeout: got 0, expected 1", nm);
    end
  endtask

  task automatic run_read(input string nm, input logic [15:0] addr, input logic [1:0] be,
                          input logic [15:0] exp, input bit miss, input logic [7:0] base);
    @(negedge clk);
    mem_read        = 1'b1;
    mem_address     = addr;
    mem_byte_enable = be;
    exp_q.push_back(exp);
    if (miss) begin
      wait_line_read(nm, {addr[15:4], 4'h0});
      line_rdata = fill_line(base);
      line_resp  = 1'b1;
      @(negedge clk);
      line_resp  = 1'b0;
      line_rdata = '0;
    end else begin
      @(negedge clk);
      chk({nm, " no_line_read"}, line_read, 1'b0);
    end
    wait_resp(nm);
    mem_read = 1'b0;
  endtask

  task automatic snoop_write(input logic [15:0] addr, input logic [7:0] fillb);
    @(negedge clk);
    line_write      = 1'b1;
    line_write_addr = addr;
    line_write_data = {16{fillb}};
    @(negedge clk);
    line_write      = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h1006, 2'b11, 16'h0706, 1'b1, 8'h00};
    vecs[1] = '{16'h100F, 2'b01, 16'h000F, 1'b0, 8'h00};
    vecs[2] = '{16'h1007, 2'b11, 16'h0706, 1'b0, 8'h00};
    vecs[3] = '{16'h1000, 2'b10, 16'h0000, 1'b0, 8'h00};
    vecs[4] = '{16'h100E, 2'b11, 16'h0F0E, 1'b0, 8'h00};
    vecs[5] = '{16'h1003, 2'b00, 16'h0003, 1'b0, 8'h00};
    vecs[6] = '{16'h1008, 2'b11, 16'h0908, 1'b0, 8'h00};
    vecs[7] = '{16'h2000, 2'b11, 16'h2120, 1'b1, 8'h20};
    vecs[8] = '{16'h2005, 2'b01, 16'h0025, 1'b0, 8'h20};
    vecs[9] = '{16'h1002, 2'b11, 16'h0302, 1'b1, 8'h00};

    reset_n         = 1'b0;
    mem_read        = 1'b0;
    mem_address     = '0;
    mem_byte_enable = 2'b11;
    line_rdata      = '0;
    line_resp       = 1'b0;
    line_write      = 1'b0;
    line_write_addr = '0;
    line_write_data = '0;

    repeat (3) @(negedge clk);
    chk("reset mem_resp", mem_resp, 1'b0);
    chk("reset mem_rdata", mem_rdata, 16'h0000);
    chk("reset line_read", line_read, 1'b0);
    chk("reset line_address", line_address, 16'h0000);
    reset_n = 1'b1;

    // Table: fill, hits of words/bytes, eviction and refetch of 0x1000.
    for (int i = 0; i < 10; i++) begin
      run_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].be, vecs[i].exp,
               vecs[i].miss, vecs[i].base);
    end

    // Snoop write to the buffered line in IDLE replaces its content.
    snoop_write(16'h1004, 8'hAA);
    run_read("snoop_hit_word", 16'h1000, 2'b11, 16'hAAAA, 1'b0, 8'h00);
    // Non-matching write leaves the buffer alone.
    snoop_write(16'h5000, 8'h55);
    run_read("snoop_other_byte", 16'h1001, 2'b01, 16'h00AA, 1'b0, 8'h00);

    // Store hits the line being fetched: first fill discarded, refetch.
    @(negedge clk);
    mem_read        = 1'b1;
    mem_address     = 16'h3000;
    mem_byte_enable = 2'b11;
    exp_q.push_back(16'h3130);
    wait_line_read("stale_first", 16'h3000);
    line_write      = 1'b1;
    line_write_addr = 16'h3008;
    line_write_data = {16{8'h77}};
    @(negedge clk);
    line_write = 1'b0;
    line_rdata = fill_line(8'h90);
    line_resp  = 1'b1;
    @(negedge clk);
    line_resp = 1'b0;
    chk("stale line_read_drop", line_read, 1'b0);
    chk("stale no_resp", mem_resp, 1'b0);
    @(negedge clk);
    chk("stale refetch_next_cycle", line_read, 1'b1);
    wait_line_read("stale_refetch", 16'h3000);
    line_rdata = fill_line(8'h30);
    line_resp  = 1'b1;
    @(negedge clk);
    line_resp = 1'b0;
    wait_resp("stale");
    mem_read = 1'b0;

    // Store and line_resp in the same cycle: stale wins.
    @(negedge clk);
    mem_read    = 1'b1;
    mem_address = 16'h4000;
    exp_q.push_back(16'h4140);
    wait_line_read("same_cycle_first", 16'h4000);
    line_rdata      = fill_line(8'h90);
    line_resp       = 1'b1;
    line_write      = 1'b1;
    line_write_addr = 16'h400C;
    line_write_data = {16{8'h77}};
    @(negedge clk);
    line_resp  = 1'b0;
    line_write = 1'b0;
    chk("same_cycle line_read_drop", line_read, 1'b0);
    chk("same_cycle no_resp", mem_resp, 1'b0);
    wait_line_read("same_cycle_refetch", 16'h4000);
    line_rdata = fill_line(8'h40);
    line_resp  = 1'b1;
    @(negedge clk);
    line_resp = 1'b0;
    wait_resp("same_cycle");
    mem_read = 1'b0;

    // Reset during FETCH drops line_read immediately.
    @(negedge clk);
    mem_read    = 1'b1;
    mem_address = 16'h6000;
    wait_line_read("reset_fetch", 16'h6000);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset line_read", line_read, 1'b0);
    chk("async_reset mem_resp", mem_resp, 1'b0);
    chk("async_reset line_address", line_address, 16'h0000);
    mem_read = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    run_read("after_reset_miss", 16'h6000, 2'b11, 16'h6160, 1'b1, 8'h60);
    run_read("after_reset_hit", 16'h600B, 2'b10, 16'h006B, 1'b0, 8'h00);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
